// File: rtl/freq_sel_pkg.sv
// freq_sel_pkg: shared widths, table entry layout and scan FSM states
package freq_sel_pkg;

    localparam int K_FIRST_W  = 14;
    localparam int INDEX_W    = 7;
    localparam int K_SECOND_W = 4;
    localparam int ENTRY_W    = K_FIRST_W + INDEX_W + K_SECOND_W;

    // Packed MSB-first: k_second [24:21], index_first [20:14], k_first [13:0]
    typedef struct packed {
        logic [K_SECOND_W-1:0] k_second;
        logic [INDEX_W-1:0]    index_first;
        logic [K_FIRST_W-1:0]  k_first;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_e;

endpackage

// File: rtl/freq_sel_table.sv
// freq_sel_table: DEPTH-entry channel table, read-first sync RAM with 1-cycle read latency
//   clk_i    block clock
//   we_i     write strobe, waddr_i/wdata_i write port
//   raddr_i  read address, rdata_o registered read data (old data on same-address write)
module freq_sel_table
    import freq_sel_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  entry_t            wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output entry_t            rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/freq_sel_sequencer.sv
// freq_sel_sequencer: walks the channel table and drives the frequency selector configuration
//   dev_clk/dev_rstn       clock, synchronous active-low reset
//   cfg_we/addr/wdata      table write port (accepted in any state)
//   cfg_num/dwell/timeout  scan length, beats per entry, DWELL cycle limit (latched at start)
//   cfg_loop               wrap to entry 0 after the last entry
//   start/stop             scan control pulses, stop has priority
//   sel_valid              selector output beat
//   k_first/index_first/k_second/entry_idx  applied entry, entry_stb on each apply
//   busy/done/err_timeout  scan status, err_timeout sticky until next start
module freq_sel_sequencer
    import freq_sel_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic                  dev_clk,
    input  logic                  dev_rstn,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [ENTRY_W-1:0]    cfg_wdata,
    input  logic [ADDR_W:0]       cfg_num,
    input  logic [15:0]           cfg_dwell,
    input  logic [23:0]           cfg_timeout,
    input  logic                  cfg_loop,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sel_valid,
    output logic [K_FIRST_W-1:0]  k_first,
    output logic [INDEX_W-1:0]    index_first,
    output logic [K_SECOND_W-1:0] k_second,
    output logic [ADDR_W-1:0]     entry_idx,
    output logic                  entry_stb,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   num_q;
    logic [15:0]       dwell_q;
    logic [23:0]       timeout_q;
    logic              loop_q;
    logic [15:0]       beats_q;
    logic [23:0]       elapsed_q;
    logic [SW-1:0]     settle_q;
    entry_t            entry_q;
    logic [ADDR_W-1:0] entry_idx_q;
    logic              entry_stb_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    entry_t            rd_data;

    logic [15:0] beats_d;
    logic [23:0] elapsed_d;
    logic [15:0] dwell_eff;
    logic        beat_hit;
    logic        tmo_hit;
    logic        last;

    freq_sel_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk_i   (dev_clk),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wdata_i (entry_t'(cfg_wdata)),
        .raddr_i (ptr_q),
        .rdata_o (rd_data)
    );

    // Saturating counters; a beat completion outranks a simultaneous timeout
    always_comb begin
        beats_d   = (sel_valid && beats_q != '1) ? beats_q + 16'd1 : beats_q;
        elapsed_d = (elapsed_q != '1) ? elapsed_q + 24'd1 : elapsed_q;
        dwell_eff = (dwell_q == '0) ? 16'd1 : dwell_q;
        beat_hit  = beats_d >= dwell_eff;
        tmo_hit   = (timeout_q != '0) && (elapsed_d == timeout_q);
        last      = ({1'b0, ptr_q} + (ADDR_W+1)'(1)) >= num_q;
    end

    always_ff @(posedge dev_clk) begin
        if (!dev_rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            num_q       <= '0;
            dwell_q     <= '0;
            timeout_q   <= '0;
            loop_q      <= 1'b0;
            beats_q     <= '0;
            elapsed_q   <= '0;
            settle_q    <= '0;
            entry_q     <= '0;
            entry_idx_q <= '0;
            entry_stb_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            entry_stb_q <= 1'b0;
            done_q      <= 1'b0;
            if (stop && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !stop) begin
                            err_q <= 1'b0;
                            if (cfg_num == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= S_LOAD;
                                busy_q    <= 1'b1;
                                ptr_q     <= '0;
                                num_q     <= cfg_num;
                                dwell_q   <= cfg_dwell;
                                timeout_q <= cfg_timeout;
                                loop_q    <= cfg_loop;
                            end
                        end
                    end
                    S_LOAD: state_q <= S_APPLY;
                    S_APPLY: begin
                        entry_q     <= rd_data;
                        entry_idx_q <= ptr_q;
                        entry_stb_q <= 1'b1;
                        settle_q    <= '0;
                        state_q     <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_q == SW'(SETTLE_CYC - 1)) begin
                            beats_q   <= '0;
                            elapsed_q <= '0;
                            state_q   <= S_DWELL;
                        end else begin
                            settle_q <= settle_q + SW'(1);
                        end
                    end
                    S_DWELL: begin
                        beats_q   <= beats_d;
                        elapsed_q <= elapsed_d;
                        if (beat_hit || tmo_hit) begin
                            if (!beat_hit) err_q <= 1'b1;
                            if (!last) begin
                                ptr_q   <= ptr_q + ADDR_W'(1);
                                state_q <= S_LOAD;
                            end else if (loop_q) begin
                                ptr_q   <= '0;
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign k_first     = entry_q.k_first;
    assign index_first = entry_q.index_first;
    assign k_second    = entry_q.k_second;
    assign entry_idx   = entry_idx_q;
    assign entry_stb   = entry_stb_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule
